// File: rtl/sprite_pkg.sv
// sprite_pkg: shared sprite constants, read-pipeline tag type and a clog2 helper.
package sprite_pkg;
  localparam int CIDXW = 3;
  localparam int SPR_ADDRW = 10;
  localparam int N_SPRITES = 4;
  localparam int IDW = 3;
  typedef struct packed {
    logic           v;
    logic [IDW-1:0] id;
  } tag_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first eligible index at or after ptr (rotate, priority-encode, un-rotate).
module rr_pick
  import sprite_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic          found,
  output logic [PW-1:0] w
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW-1:0]  idx;
  logic [PW:0]    sum;
  always_comb begin
    dbl = {eligible, eligible};
    rot = N'(dbl >> ptr);
    found = |rot;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) if (rot[j]) idx = PW'(j);
    sum = {1'b0, idx} + {1'b0, ptr};
    w = PW'(sum >= (PW+1)'(N) ? sum - (PW+1)'(N) : sum);
  end
endmodule

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one synchronous sprite ROM between N_REQ engines,
// with fixed-latency per-requester read return and a sticky starvation flag.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDRW    = SPR_ADDRW,
  parameter int DATAW    = CIDXW,
  parameter int ROM_LAT  = 1,
  parameter int MAX_WAIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*ADDRW-1:0] addr,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       rd_valid,
  output logic [DATAW-1:0]       rd_data,
  output logic [ADDRW-1:0]       rom_addr,
  input  logic [DATAW-1:0]       rom_data,
  output logic                   overrun
);
  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(MAX_WAIT + 1);
  logic [N_REQ-1:0] gnt_q, gnt_d, rd_valid_q, rd_valid_d, eligible;
  logic [ADDRW-1:0] rom_addr_q, rom_addr_d;
  logic [DATAW-1:0] hold_q, hold_d;
  logic             overrun_q, overrun_d, found, sat;
  logic [PW-1:0]    ptr_q, ptr_d, w;
  logic [CW-1:0]    wait_q [N_REQ];
  logic [CW-1:0]    wait_d [N_REQ];
  logic [ADDRW-1:0] a [N_REQ];
  tag_t             tag_q [ROM_LAT];
  tag_t             tag_d [ROM_LAT];
  genvar g;
  for (g = 0; g < N_REQ; g++) begin : g_unpack
    assign a[g] = addr[g*ADDRW +: ADDRW];
  end
  // Masking the requester being granted this cycle prevents back-to-back double grants.
  assign eligible = req & ~gnt_q;
  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .found    (found),
    .w        (w)
  );
  always_comb begin
    gnt_d = found ? N_REQ'(1) << w : '0;
    rom_addr_d = found ? a[w] : rom_addr_q;
    ptr_d = line ? '0 : !found ? ptr_q : w == PW'(N_REQ - 1) ? '0 : w + 1'b1;
    tag_d[0] = '{v: found, id: IDW'(w)};
    for (int i = 1; i < ROM_LAT; i++) tag_d[i] = tag_q[i-1];
    rd_valid_d = N_REQ'(tag_q[ROM_LAT-1].v) << tag_q[ROM_LAT-1].id;
    hold_d = |rd_valid_q ? rom_data : hold_q;
    sat = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      wait_d[i] = (!req[i] || gnt_d[i]) ? '0 :
                  (gnt_q[i] || wait_q[i] == CW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + 1'b1;
      sat = sat | (wait_d[i] == CW'(MAX_WAIT));
    end
    overrun_d = sat | (overrun_q & ~line);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q      <= '0;
      rd_valid_q <= '0;
      rom_addr_q <= '0;
      hold_q     <= '0;
      overrun_q  <= 1'b0;
      ptr_q      <= '0;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= '0;
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= '0;
    end else begin
      gnt_q      <= gnt_d;
      rd_valid_q <= rd_valid_d;
      rom_addr_q <= rom_addr_d;
      hold_q     <= hold_d;
      overrun_q  <= overrun_d;
      ptr_q      <= ptr_d;
      for (int i = 0; i < N_REQ; i++) wait_q[i] <= wait_d[i];
      for (int i = 0; i < ROM_LAT; i++) tag_q[i] <= tag_d[i];
    end
  end
  // The ROM output is only meaningful in the valid cycle; otherwise present the last returned word.
  assign rd_data  = |rd_valid_q ? rom_data : hold_q;
  assign gnt      = gnt_q;
  assign rd_valid = rd_valid_q;
  assign rom_addr = rom_addr_q;
  assign overrun  = overrun_q;
endmodule

// File: doc/sprite_rom_arbiter.md
Name: sprite_rom_arbiter

Overview:
Shares one synchronous sprite bitmap ROM between N_REQ sprite engines, which otherwise OR their addresses onto a single bus. Uses a round-robin arbiter and a registered request/grant handshake. Returns read data to the granted requester via a per-requester valid pulse, with a fixed latency. Sits between the sprite engines (pixel-clock domain) and the ROM instance. Also provides a sticky starvation flag so the top level can detect that a scanline's pixel budget was missed.

Parameters:
N_REQ, 4, number of sprite requesters (2..8)
ADDRW, 10, ROM address width (ceil log2 of sprite width*height; 30x32 -> 10)
DATAW, 3, ROM data width = colour index width (CIDXW)
ROM_LAT, 1, ROM read latency in clocks, from address registered to data valid (1..2)
MAX_WAIT, 8, cycles a request may wait ungranted before overrun is flagged (>=1)

Ports:
clk  in  1  pixel clock (clk25 at top level)
rst  in  1  asynchronous, active-high reset
line  in  1  one-cycle pulse at start of each scanline
req  in  N_REQ  per-requester read request, level
addr  in  N_REQ*ADDRW  packed addresses; requester i uses bits [i*ADDRW +: ADDRW]
gnt  out  N_REQ  one-hot grant pulse (registered)
rd_valid  out  N_REQ  one-hot read-data-valid pulse (registered)
rd_data  out  DATAW  read data, qualified by rd_valid
rom_addr  out  ADDRW  address to the shared ROM (registered)
rom_data  in  DATAW  ROM output
overrun  out  1  sticky starvation flag

Behaviour:
- Reset (async, any time): gnt=0, rd_valid=0, rd_data=0, rom_addr=0, overrun=0, rr pointer ptr=0, all wait counters=0, latency pipeline cleared. In-flight reads are discarded; no rd_valid is issued for them after release.
- Handshake: requester raises req[i] and holds addr[i] stable until it sees gnt[i]=1. It may drop req, or present a new addr with req, in the cycle after gnt.
- Arbitration (cycle t): eligible = req & ~gnt, which masks the requester currently being granted and prevents double grants. Winner w is the first eligible index searching ptr, ptr+1, ... mod N_REQ.
- On the edge ending cycle t with a winner: gnt <= onehot(w); rom_addr <= addr[w]; ptr <= (w+1) mod N_REQ; pipeline tag <= {valid=1, id=w}. With no winner: gnt <= 0; rom_addr holds; ptr holds.
- Latency: gnt[w] and rom_addr are valid in cycle t+1. rd_valid[w]=1 and rd_data=rom_data in cycle t+1+ROM_LAT. The tag shift register has depth ROM_LAT. rd_data holds its last value when no valid is present.
- Throughput: one grant per cycle across requesters. A single continuously requesting requester is granted every other cycle because of the mask.
- line pulse: ptr <= 0. This overrides the ptr update from a grant in the same cycle. The grant itself still occurs.
- Wait counter i (saturating at MAX_WAIT): increments while req[i] && !gnt[i]. Clears when gnt[i] is issued or req[i]=0.
- overrun: set when any counter reaches MAX_WAIT. Cleared only by rst or a line pulse. If set and line coincide, set wins.
- All arithmetic is modulo N_REQ on ptr. Counters use ceil log2(MAX_WAIT+1) bits.

Decomposition:
- sprite_pkg: CIDXW=3, sprite ROM ADDRW, N_SPRITES default, function clog2 helper. Shared by sprite2, rom, and this block.
- Sub-module rr_pick (combinational): inputs eligible[N_REQ] and ptr; outputs found and w. Implemented as a rotate, priority-encode, un-rotate. It is reused by future arbiters (e.g. the obstacle engine).
- Top level ties rom.addr = rom_addr and rom.data = rom_data, replacing the OR of sprite addresses.

Test Plan (ROM model: data = addr[2:0], ROM_LAT=1, N_REQ=4):
- Single read: req[0]=1, addr0=0x05 at cycle 0, all others idle -> gnt=0001 and rom_addr=0x05 in cycle 1; rd_valid=0001 and rd_data=5 in cycle 2; drop req in cycle 2 -> no further gnt.
- Round-robin fairness: all four req held high, addrs 1,2,3,4 -> gnt sequence 0001,0010,0100,1000,0001 on cycles 1..5; rd_data 1,2,3,4,1 on cycles 2..6 with matching rd_valid.
- line priority: ptr=2 (after a grant to 1) with line pulse coincident with a grant to 2, all requesting -> next grant goes to 0, not 3.
- Single hog: only req[1] held continuously -> gnt[1] on cycles 1,3,5,...; never two consecutive.
- Overrun: MAX_WAIT=2, all four requesting from cycle 0 -> requester 3 reaches count 2 before its grant, so overrun=1 and stays 1; a line pulse with no starved requester clears it next cycle.
- Reset mid-flight: assert rst in cycle 1 of the single-read scenario -> gnt, rd_valid, and rom_addr go to 0 immediately; no rd_valid after release; the first grant after release goes to index 0.
